fp16_mul_pipe: RTL
==================

// Module: fp16_mul_pipe
// PURPOSE
//  3-stage pipelined IEEE-754 binary16 multiplier with a valid/ready handshake.
//  Sits directly upstream of the FP16 adder in the MAC datapath; its product
//  is the adder's 'a' operand. Rounding is round-to-nearest-even (RNE).
//  Raises per-result exception flags.
// PARAMETERS
//  EXP_W   5   exponent width. Fixed for binary16; do not override.
//  MAN_W   10  stored mantissa width. Fixed for binary16.
//  BIAS    15  exponent bias.
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous reset, active-high
//  in_valid   in   1   a/b hold a valid operand pair
//  in_ready   out  1   pipeline accepts the pair this cycle
//  a          in   16  operand A, binary16
//  b          in   16  operand B, binary16
//  out_valid  out  1   out/flags hold a valid result
//  out_ready  in   1   downstream (adder stage) accepts the result
//  out        out  16  product, binary16
//  flags      out  4   {invalid, overflow, underflow, inexact} for out
// BEHAVIOUR
//  - Reset (async, while rst=1): all stage valids=0, out_valid=0, out=16'h0000,
//    flags=4'b0. in_ready=1 during and after reset. In-flight ops are discarded.
//  - Transfer rules: a transfer occurs on a clock edge where valid&&ready.
//    adv = !out_valid || out_ready. The whole pipeline shifts only when adv=1.
//    in_ready = adv (combinational). Bubbles are not compressed.
//  - Latency: an operand pair accepted at edge N appears on out at edge N+3
//    when adv=1 throughout. Throughput is 1/cycle. Results stay in order.
//  - Stall: while out_valid && !out_ready, out/flags/out_valid hold stable and
//    no stage register changes.
//  - S1, unpack: sign = sa^sb. Classify each operand as zero, subnormal,
//    normal, inf or NaN. Insert the hidden bit. Exponent sum is 7-bit signed:
//    ea+eb-BIAS (subnormal exponent is treated as 1).
//  - S2: 11x11 -> 22-bit mantissa product. Class info passes alongside.
//  - S3, normalise/round/pack:
//    - If the 22-bit product has bit21 set, shift right 1 and increment the exponent.
//    - Guard, round and sticky bits are taken from the discarded bits.
//    - RNE may carry out of the mantissa. On carry, renormalise and increment
//      the exponent again.
//    - exp >= 31 after rounding: out = {sign,5'h1F,10'h0}; overflow=1, inexact=1.
//    - exp <= 0: underflow path (see CONFIGURATION).
//  - Special cases, priority top-down:
//    1. Any NaN input -> 16'h7E00, invalid=1.
//    2. inf*0 -> 16'h7E00, invalid=1.
//    3. inf*x -> {sign,15'h7C00}.
//    4. 0*x -> {sign,15'h0000}.
//    Special-case results carry no overflow, underflow or inexact flag.
//  - flags are registered with out. They are valid only when out_valid=1 and
//    are 0 after reset.
// CONFIGURATION
//  FP16_MUL_SUBNORM_EN defined:
//    - Subnormal inputs are used unnormalised. S1 computes the leading-zero
//      count and left-shifts the mantissa.
//    - Results with exp<=0 are right-shifted into subnormal form (sticky
//      collected), then RNE-rounded. Rounding up may give the min normal 0x0400.
//    - underflow=1 when the result is tiny and inexact.
//  FP16_MUL_SUBNORM_EN undefined (flush-to-zero):
//    - Subnormal inputs are treated as signed zero.
//    - Any result with exp<=0 after rounding becomes {sign,15'h0}, with
//      underflow=1 and inexact=1.
//    - Latency is the same in both builds.
// TESTING
//  1. a=3C00,b=4000, out_ready=1, single pulse -> out=4000, flags=0, 3 cycles later.
//  2. a=7BFF,b=7BFF -> out=7C00, flags=0101 (overflow, inexact).
//  3. a=7C00,b=0000 -> out=7E00, flags=1000; a=FC00,b=4000 -> out=FC00, flags=0.
//  4. Stream 8 pairs (k*3C00-family values) back-to-back; hold out_ready=0 for
//     cycles 5-6. -> in_ready=0 during stall, out stable, all 8 results in
//     order, none lost or duplicated.
//  5. a=0001,b=3C00 -> with FP16_MUL_SUBNORM_EN: out=0001, flags=0.
//     Without it: out=0000, flags=0011.
//  6. Assert rst for 1 cycle with 2 ops in flight -> out_valid=0 immediately;
//     no stale result ever emerges; next op gives the correct result 3 cycles
//     after acceptance.

Source files
------------

// File: rtl/fp16_mul_pipe.sv
// fp16_mul_pipe: pipelined binary16 multiplier, RNE rounding, valid/ready.
// Define FP16_MUL_SUBNORM_EN for gradual underflow; default flushes to zero.
module fp16_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic [3:0]  flags
);

  typedef struct packed {
    logic              sign;
    logic              spec;
    logic [15:0]       sres;
    logic [3:0]        sflg;
    logic signed [6:0] ex;
    logic [MAN_W:0]    ma;
    logic [MAN_W:0]    mb;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic              spec;
    logic [15:0]       sres;
    logic [3:0]        sflg;
    logic signed [6:0] ex;
    logic [21:0]       prod;
  } s2_t;

  logic        adv;
  logic        v0, v1, v2;
  logic [15:0] a0, b0;
  s1_t         s1, s1_d;
  s2_t         s2, s2_d;
  logic [15:0] res;
  logic [3:0]  res_flg;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  fa, fb;
  logic              za, zb, da, db;
  logic              ia, ib, na, nb;
  logic              zsa, zsb;
  logic [MAN_W:0]    ma0, mb0, ma, mb;
  logic signed [6:0] xa, xb;

  assign ea  = a0[14:10];
  assign eb  = b0[14:10];
  assign fa  = a0[9:0];
  assign fb  = b0[9:0];
  assign za  = (ea == '0) && (fa == '0);
  assign zb  = (eb == '0) && (fb == '0);
  assign da  = (ea == '0) && (fa != '0);
  assign db  = (eb == '0) && (fb != '0);
  assign ia  = (ea == '1) && (fa == '0);
  assign ib  = (eb == '1) && (fb == '0);
  assign na  = (ea == '1) && (fa != '0);
  assign nb  = (eb == '1) && (fb != '0);
  assign ma0 = {ea != '0, fa};
  assign mb0 = {eb != '0, fb};

`ifdef FP16_MUL_SUBNORM_EN
  function automatic logic [3:0] lzc(input logic [MAN_W:0] m);
    lzc = 4'd11;
    for (int i = 0; i <= MAN_W; i++)
      if (m[i]) lzc = 4'(MAN_W - i);
  endfunction

  logic [3:0] lza, lzb;

  assign lza = lzc(ma0);
  assign lzb = lzc(mb0);
  assign ma  = ma0 << lza;
  assign mb  = mb0 << lzb;
  assign xa  = 7'(da ? 5'd1 : ea) - 7'(lza);
  assign xb  = 7'(db ? 5'd1 : eb) - 7'(lzb);
  assign zsa = za;
  assign zsb = zb;
`else
  assign ma  = ma0;
  assign mb  = mb0;
  assign xa  = 7'(da ? 5'd1 : ea);
  assign xb  = 7'(db ? 5'd1 : eb);
  assign zsa = za | da;
  assign zsb = zb | db;
`endif

  always_comb begin
    s1_d      = '0;
    s1_d.sign = a0[15] ^ b0[15];
    s1_d.ex   = xa + xb - 7'(BIAS);
    s1_d.ma   = ma;
    s1_d.mb   = mb;
    s1_d.spec = 1'b1;
    if (na || nb) begin
      s1_d.sres = 16'h7E00;
      s1_d.sflg = 4'b1000;
    end else if ((ia || ib) && (zsa || zsb)) begin
      s1_d.sres = 16'h7E00;
      s1_d.sflg = 4'b1000;
    end else if (ia || ib) begin
      s1_d.sres = {s1_d.sign, 15'h7C00};
    end else if (za || zb) begin
      s1_d.sres = {s1_d.sign, 15'h0000};
`ifndef FP16_MUL_SUBNORM_EN
    end else if (da || db) begin
      // a flushed subnormal operand is a lost nonzero value
      s1_d.sres = {s1_d.sign, 15'h0000};
      s1_d.sflg = 4'b0011;
`endif
    end else begin
      s1_d.spec = 1'b0;
    end
  end

  always_comb begin
    s2_d.sign = s1.sign;
    s2_d.spec = s1.spec;
    s2_d.sres = s1.sres;
    s2_d.sflg = s1.sflg;
    s2_d.ex   = s1.ex;
    s2_d.prod = 22'(s1.ma) * 22'(s1.mb);
  end

  logic [21:0]       x;
  logic signed [6:0] en, er;
  logic [11:0]       rsum;
  logic [9:0]        frac;
  logic              g, st, inx;
`ifdef FP16_MUL_SUBNORM_EN
  logic signed [6:0] sh;
  logic [4:0]        shc;
  logic [21:0]       gbit;
  logic [10:0]       t, tr;
  logic              sg, ss;
`endif

  always_comb begin
    res     = 16'h0000;
    res_flg = 4'b0000;
    x    = s2.prod[21] ? s2.prod : {s2.prod[20:0], 1'b0};
    en   = s2.ex + 7'(s2.prod[21]);
    g    = x[10];
    st   = |x[9:0];
    inx  = g | st;
    rsum = {1'b0, x[21:11]} + 12'(g & (st | x[11]));
    er   = en + 7'(rsum[11]);
    frac = rsum[11] ? rsum[10:1] : rsum[9:0];
`ifdef FP16_MUL_SUBNORM_EN
    // bit 21 of x lands on 2^-15 when en is 0
    sh   = 7'sd12 - en;
    shc  = (sh > 7'sd24) ? 5'd24 : sh[4:0];
    gbit = 22'(1) << (shc - 5'd1);
    t    = 11'(x >> shc);
    sg   = |(x & gbit);
    ss   = |(x & (gbit - 22'd1));
    tr   = t + 11'(sg & (ss | t[0]));
`endif
    if (s2.spec) begin
      res     = s2.sres;
      res_flg = s2.sflg;
`ifdef FP16_MUL_SUBNORM_EN
    end else if (en <= 7'sd0) begin
      res     = {s2.sign, 4'b0000, tr};
      res_flg = {2'b00, sg | ss, sg | ss};
`endif
    end else if (er >= 7'sd31) begin
      res     = {s2.sign, 15'h7C00};
      res_flg = 4'b0101;
`ifndef FP16_MUL_SUBNORM_EN
    end else if (er <= 7'sd0) begin
      res     = {s2.sign, 15'h0000};
      res_flg = 4'b0011;
`endif
    end else begin
      res     = {s2.sign, er[4:0], frac};
      res_flg = {3'b000, inx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      a0        <= '0;
      b0        <= '0;
      s1        <= '0;
      s2        <= '0;
      out       <= '0;
      flags     <= '0;
    end else if (adv) begin
      v0        <= in_valid;
      a0        <= a;
      b0        <= b;
      v1        <= v0;
      s1        <= s1_d;
      v2        <= v1;
      s2        <= s2_d;
      out_valid <= v2;
      out       <= res;
      flags     <= res_flg;
    end
  end

endmodule
